rf_wb_arbiter: RTL and testbench

//  Shares the register file's single write port (rfwe/RFWA/RFWD) among NREQ writeback requesters.

---
 rtl/rf_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/rf_wb_arbiter.sv | 121 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants for the register-file writeback arbiter.
// Optional build macro RF_WB_PERF_EN is consumed by rf_wb_arbiter.
package rf_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 32;
  localparam logic [RF_AW-1:0] RF_ZERO = 5'd0;

  localparam int WB_ALU  = 0;
  localparam int WB_MEM  = 1;
  localparam int WB_LINK = 2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req at or after ptr.
// Pointer state is owned by the caller.
module rr_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = 3,
  localparam int IW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  int  j;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (en && !found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin share of the register-file write port with one output slot.
// Define RF_WB_PERF_EN to add conflict_cnt / stall_cnt counters.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               wr_stall,
  output logic               rfwe,
  output logic [AW-1:0]      RFWA,
  output logic [DW-1:0]      RFWD,
  output logic               pend_valid,
  output logic [AW-1:0]      pend_addr
`ifdef RF_WB_PERF_EN
  ,
  output logic [31:0]        conflict_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int IW = idx_w(NREQ);

  logic          slot_v_q, slot_v_d;
  logic [AW-1:0] wa_q, wa_d;
  logic [DW-1:0] wd_q, wd_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic            arb_en;
  logic            xfer;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gidx;
  logic [AW-1:0]   g_addr;
  logic [DW-1:0]   g_data;

  // The slot accepts in the same cycle it drains.
  assign arb_en = (!slot_v_q || !wr_stall) && !rst;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gidx)
  );

  assign req_ready  = gnt;
  assign xfer       = |gnt;
  assign g_addr     = req_addr[int'(gidx)*AW +: AW];
  assign g_data     = req_data[int'(gidx)*DW +: DW];
  assign rfwe       = slot_v_q && !wr_stall && !rst;
  assign RFWA       = wa_q;
  assign RFWD       = wd_q;
  assign pend_valid = slot_v_q;
  assign pend_addr  = wa_q;

  always_comb begin
    slot_v_d = slot_v_q;
    wa_d     = wa_q;
    wd_d     = wd_q;
    ptr_d    = ptr_q;
    if (rfwe) slot_v_d = 1'b0;
    if (xfer) begin
      if (int'(gidx) == NREQ - 1) ptr_d = '0;
      else ptr_d = gidx + IW'(1);
      // r0 writes complete the handshake but never occupy the slot.
      if (g_addr != AW'(RF_ZERO)) begin
        slot_v_d = 1'b1;
        wa_d     = g_addr;
        wd_d     = g_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_v_q <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
      ptr_q    <= '0;
    end else begin
      slot_v_q <= slot_v_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      ptr_q    <= ptr_d;
    end
  end

`ifdef RF_WB_PERF_EN
  logic [31:0] conf_q, conf_d;
  logic [31:0] stl_q, stl_d;

  always_comb begin
    conf_d = conf_q;
    stl_d  = stl_q;
    if ($countones(req_valid) >= 2) conf_d = conf_q + 32'd1;
    if (slot_v_q && wr_stall) stl_d = stl_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conf_q <= '0;
      stl_q  <= '0;
    end else begin
      conf_q <= conf_d;
      stl_q  <= stl_d;
    end
  end

  assign conflict_cnt = conf_q;
  assign stall_cnt    = stl_q;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed scenarios then random traffic.
// Counter checks are active when RF_WB_PERF_EN is defined.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = RF_AW;
  localparam int DW   = RF_DW;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]    req_ready;
  logic               wr_stall = 1'b0;
  logic               rfwe;
  logic [AW-1:0]      RFWA;
  logic [DW-1:0]      RFWD;
  logic               pend_valid;
  logic [AW-1:0]      pend_addr;
`ifdef RF_WB_PERF_EN
  logic [31:0]        conflict_cnt;
  logic [31:0]        stall_cnt;
`endif

  rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .wr_stall   (wr_stall),
    .rfwe       (rfwe),
    .RFWA       (RFWA),
    .RFWD       (RFWD),
    .pend_valid (pend_valid),
    .pend_addr  (pend_addr)
`ifdef RF_WB_PERF_EN
    ,
    .conflict_cnt (conflict_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t expq[$];

  logic [AW-1:0] ta[NREQ];
  logic [DW-1:0] td[NREQ];

  // Reference state: who is next in line, whether a write is pending.
  int            m_ptr   = 0;
  bit            m_full  = 0;
  logic [AW-1:0] m_addr  = '0;
  int            m_conf  = 0;
  int            m_stall = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic [NREQ-1:0] v, input logic st,
                      input logic r);
    int w;
    int nv;
    logic [NREQ-1:0] exp_rdy;
    bit exp_we;
    @(posedge clk);
    #1;
    rst       = r;
    wr_stall  = st;
    req_valid = v;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = ta[i];
      req_data[i*DW +: DW] = td[i];
    end
    #1;
    w = -1;
    exp_rdy = '0;
    exp_we = 0;
    if (!r) begin
      if (!m_full || !st) begin
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && v[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      end
      if (w >= 0) exp_rdy[w] = 1'b1;
      exp_we = m_full && !st;
    end
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("rfwe", 64'(rfwe), 64'(exp_we));
    check("pend_valid", 64'(pend_valid), 64'(m_full));
    check("pend_addr", 64'(pend_addr), 64'(m_addr));
`ifdef RF_WB_PERF_EN
    check("conflict_cnt", 64'(conflict_cnt), 64'(m_conf));
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
    if (r) begin
      m_ptr = 0; m_full = 0; m_addr = '0;
      m_conf = 0; m_stall = 0;
      expq.delete();
    end else begin
      nv = 0;
      for (int i = 0; i < NREQ; i++) nv += int'(v[i]);
      if (nv >= 2) m_conf++;
      if (m_full && st) m_stall++;
      if (exp_we) m_full = 0;
      if (w >= 0) begin
        m_ptr = (w + 1) % NREQ;
        if (ta[w] != '0) begin
          expq.push_back('{a: ta[w], d: td[w]});
          m_full = 1;
          m_addr = ta[w];
        end
      end
    end
  endtask

  // Monitor: every register-file write must match the next expected one.
  always @(negedge clk) begin
    if (rfwe === 1'b1) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got RFWA=%0h RFWD=%0h expected none",
                 RFWA, RFWD);
      end else begin
        wr_t e;
        e = expq.pop_front();
        if (RFWA !== e.a || RFWD !== e.d) begin
          errors++;
          $display("FAIL rf_write: got %0h/%0h expected %0h/%0h",
                   RFWA, RFWD, e.a, e.d);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      ta[i] = '0;
      td[i] = '0;
    end
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);

    ta[WB_ALU] = 5'd5; td[WB_ALU] = 32'hDEAD_BEEF;
    step(3'b001, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0);

    ta[WB_ALU] = 5'd1; ta[WB_MEM] = 5'd2; ta[WB_LINK] = 5'd3;
    td[WB_ALU] = 32'h11; td[WB_MEM] = 32'h22; td[WB_LINK] = 32'h33;
    repeat (3) step(3'b111, 1'b0, 1'b0);
    repeat (2) step(3'b000, 1'b0, 1'b0);

    ta[WB_ALU] = 5'd7; td[WB_ALU] = 32'h7777;
    step(3'b001, 1'b0, 1'b0);
    ta[WB_MEM] = 5'd8; td[WB_MEM] = 32'h8888;
    repeat (4) step(3'b010, 1'b1, 1'b0);
    step(3'b010, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0);

    ta[WB_LINK] = 5'd0; td[WB_LINK] = 32'h1234;
    step(3'b100, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0);

    ta[WB_ALU] = 5'd9; td[WB_ALU] = 32'h9999;
    step(3'b001, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b1);
    repeat (2) step(3'b000, 1'b0, 1'b0);

    step(3'b000, 1'b0, 1'b1);
    ta[WB_ALU] = 5'd4; ta[WB_MEM] = 5'd6;
    step(3'b011, 1'b0, 1'b0);
    repeat (2) step(3'b011, 1'b1, 1'b0);
    repeat (2) step(3'b011, 1'b0, 1'b0);
    repeat (3) step(3'b000, 1'b0, 1'b0);

    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        ta[i] = ($urandom_range(0, 3) == 0) ? 5'd0 : AW'($urandom);
        td[i] = $urandom;
      end
      step(NREQ'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 99) == 0);
    end

    repeat (4) step(3'b000, 1'b0, 1'b0);
    check("queue_drained", 64'(expq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
